tl_a_channel_queue: RTL and testbench

//  Elastic buffer for one TileLink-UL A channel (opcode/param/size/source/address/mask/data/corrupt).

---
 rtl/tl_a_pkg.sv | 36 +++
 rtl/tl_queue_mem.sv | 24 ++
 rtl/tl_a_channel_queue.sv | 128 ++++++++++++
 tb/tb_tl_a_channel_queue.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tl_a_pkg.sv
// Shared TileLink-UL A-channel definitions: field widths, opcode codes and
// the packed beat type used by the A-channel queue and its neighbours.
package tl_a_pkg;

  localparam int OPCODE_W = 3;
  localparam int PARAM_W  = 3;
  localparam int SIZE_W   = 4;

  // Default channel geometry; the queue's parameters default to these.
  localparam int TL_SRC_W  = 5;
  localparam int TL_ADDR_W = 31;
  localparam int TL_DATA_W = 32;
  localparam int TL_MASK_W = TL_DATA_W / 8;

  localparam logic [OPCODE_W-1:0] OP_PUT_FULL    = 3'd0;
  localparam logic [OPCODE_W-1:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [OPCODE_W-1:0] OP_ARITH       = 3'd2;
  localparam logic [OPCODE_W-1:0] OP_LOGIC       = 3'd3;
  localparam logic [OPCODE_W-1:0] OP_GET         = 3'd4;
  localparam logic [OPCODE_W-1:0] OP_HINT        = 3'd5;
  localparam logic [OPCODE_W-1:0] OP_ACQUIRE     = 3'd6;

  // One A beat at the default geometry, MSB-first in the same field order
  // the queue packs into its storage.
  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [PARAM_W-1:0]   param;
    logic [SIZE_W-1:0]    size;
    logic [TL_SRC_W-1:0]  source;
    logic [TL_ADDR_W-1:0] address;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } tl_a_beat_t;

endpackage

// File: rtl/tl_queue_mem.sv
// DEPTH x W register array with one synchronous write port and one
// asynchronous read port. Storage is deliberately not reset.
module tl_queue_mem #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                     clock,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  // Write the addressed entry on an enabled rising edge.
  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/tl_a_channel_queue.sv
// Elastic DEPTH-entry circular FIFO for one TileLink-UL A channel.
// Optional feature macro: TL_A_QUEUE_FLOW_EN -- when defined, an empty queue
// passes an incoming beat straight to deq_* in the same cycle (0-cycle
// bypass); when undefined the minimum enq->deq latency is one cycle.
//
// Handshake: a beat transfers on a port in any cycle where valid and ready
// are both high at the rising clock edge. enq_ready depends only on queue
// state (never on enq_valid or deq_ready); once deq_valid rises, deq_* holds
// stable until deq_ready is seen high.
module tl_a_channel_queue
  import tl_a_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = TL_ADDR_W,
  parameter int SRC_W  = TL_SRC_W,
  parameter int DATA_W = TL_DATA_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enq_valid,
  output logic                       enq_ready,
  input  logic [OPCODE_W-1:0]        enq_opcode,
  input  logic [PARAM_W-1:0]         enq_param,
  input  logic [SIZE_W-1:0]          enq_size,
  input  logic [SRC_W-1:0]           enq_source,
  input  logic [ADDR_W-1:0]          enq_address,
  input  logic [DATA_W/8-1:0]        enq_mask,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       enq_corrupt,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [OPCODE_W-1:0]        deq_opcode,
  output logic [PARAM_W-1:0]         deq_param,
  output logic [SIZE_W-1:0]          deq_size,
  output logic [SRC_W-1:0]           deq_source,
  output logic [ADDR_W-1:0]          deq_address,
  output logic [DATA_W/8-1:0]        deq_mask,
  output logic [DATA_W-1:0]          deq_data,
  output logic                       deq_corrupt,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int BEAT_W = OPCODE_W + PARAM_W + SIZE_W + SRC_W + ADDR_W
                        + DATA_W/8 + DATA_W + 1;

  logic [PTR_W-1:0]  r_enq_ptr;
  logic [PTR_W-1:0]  r_deq_ptr;
  logic              r_maybe_full;
  logic              r_rst_done;

  logic              w_ptr_match;
  logic              w_empty;
  logic              w_full;
  logic              w_enq_fire;
  logic              w_deq_fire;
  logic              w_do_enq;
  logic              w_do_deq;
  logic [BEAT_W-1:0] w_enq_beat;
  logic [BEAT_W-1:0] w_mem_rdata;
  logic [BEAT_W-1:0] w_head;

  assign w_ptr_match = (r_enq_ptr == r_deq_ptr);
  assign w_empty     = w_ptr_match & ~r_maybe_full;
  assign w_full      = w_ptr_match &  r_maybe_full;

  assign enq_ready   = r_rst_done & ~w_full;
  assign w_enq_fire  = enq_valid & enq_ready;
  assign w_deq_fire  = deq_valid & deq_ready;

  assign w_enq_beat  = {enq_opcode, enq_param, enq_size, enq_source,
                        enq_address, enq_mask, enq_data, enq_corrupt};

`ifdef TL_A_QUEUE_FLOW_EN
  // An empty queue presents the incoming beat directly; if it is taken in
  // the same cycle it never touches storage. Gated by r_rst_done so nothing
  // is offered while reset is in effect.
  logic w_bypass;
  assign w_bypass  = w_empty & enq_valid & r_rst_done;
  assign deq_valid = ~w_empty | w_bypass;
  assign w_head    = w_empty ? w_enq_beat : w_mem_rdata;
  assign w_do_enq  = w_enq_fire & ~(w_empty & deq_ready);
  assign w_do_deq  = w_deq_fire & ~w_empty;
`else
  assign deq_valid = ~w_empty;
  assign w_head    = w_mem_rdata;
  assign w_do_enq  = w_enq_fire;
  assign w_do_deq  = w_deq_fire;
`endif

  assign {deq_opcode, deq_param, deq_size, deq_source,
          deq_address, deq_mask, deq_data, deq_corrupt} = w_head;

  // Full reads as DEPTH: the pointer difference is 0 and the top bit is set.
  assign count = {w_full, r_enq_ptr - r_deq_ptr};

  tl_queue_mem #(
    .DEPTH (DEPTH),
    .W     (BEAT_W)
  ) u_mem (
    .clock   (clock),
    .i_we    (w_do_enq),
    .i_waddr (r_enq_ptr),
    .i_wdata (w_enq_beat),
    .i_raddr (r_deq_ptr),
    .o_rdata (w_mem_rdata)
  );

  // First edge after reset release arms the enqueue side.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_rst_done <= 1'b0;
    else          r_rst_done <= 1'b1;
  end

  // Pointer and maybe_full bookkeeping; reset discards all buffered beats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_enq_ptr    <= '0;
      r_deq_ptr    <= '0;
      r_maybe_full <= 1'b0;
    end else begin
      if (w_do_enq) r_enq_ptr <= r_enq_ptr + PTR_W'(1);
      if (w_do_deq) r_deq_ptr <= r_deq_ptr + PTR_W'(1);
      if (w_do_enq != w_do_deq) r_maybe_full <= w_do_enq;
    end
  end

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// Directed bench for tl_a_channel_queue (default DEPTH=2 geometry).
// Build with +define+TL_A_QUEUE_FLOW_EN to also cover the bypass path.
module tb_tl_a_channel_queue;
  import tl_a_pkg::*;

  logic                 clock;
  logic                 reset_n;
  logic                 enq_valid;
  logic                 enq_ready;
  logic [2:0]           enq_opcode;
  logic [2:0]           enq_param;
  logic [3:0]           enq_size;
  logic [4:0]           enq_source;
  logic [30:0]          enq_address;
  logic [3:0]           enq_mask;
  logic [31:0]          enq_data;
  logic                 enq_corrupt;
  logic                 deq_valid;
  logic                 deq_ready;
  logic [2:0]           deq_opcode;
  logic [2:0]           deq_param;
  logic [3:0]           deq_size;
  logic [4:0]           deq_source;
  logic [30:0]          deq_address;
  logic [3:0]           deq_mask;
  logic [31:0]          deq_data;
  logic                 deq_corrupt;
  logic [1:0]           count;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [4:0] exp_q[$];

  tl_a_channel_queue #(.DEPTH(2), .ADDR_W(31), .SRC_W(5), .DATA_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enq_valid   (enq_valid),
    .enq_ready   (enq_ready),
    .enq_opcode  (enq_opcode),
    .enq_param   (enq_param),
    .enq_size    (enq_size),
    .enq_source  (enq_source),
    .enq_address (enq_address),
    .enq_mask    (enq_mask),
    .enq_data    (enq_data),
    .enq_corrupt (enq_corrupt),
    .deq_valid   (deq_valid),
    .deq_ready   (deq_ready),
    .deq_opcode  (deq_opcode),
    .deq_param   (deq_param),
    .deq_size    (deq_size),
    .deq_source  (deq_source),
    .deq_address (deq_address),
    .deq_mask    (deq_mask),
    .deq_data    (deq_data),
    .deq_corrupt (deq_corrupt),
    .count       (count)
  );

  // Clock: 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_beat(input logic [2:0] op, input logic [4:0] src,
                            input logic [30:0] addr, input logic [31:0] data);
    enq_opcode  = op;
    enq_param   = 3'd0;
    enq_size    = 4'd2;
    enq_source  = src;
    enq_address = addr;
    enq_mask    = 4'hF;
    enq_data    = data;
    enq_corrupt = 1'b0;
  endtask

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pops;
    reset_n   = 1'b0;
    enq_valid = 1'b1;
    deq_ready = 1'b0;
    drive_beat(OP_GET, 5'd1, 31'h0, 32'h0);

    // Reset held with enq_valid high: nothing accepted or offered.
    tick(); tick();
    check("rst_enq_ready", enq_ready, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_count", count, 0);

    enq_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rel_enq_ready_pre", enq_ready, 0);
    tick();
    check("rel_enq_ready_post", enq_ready, 1);

    // Fill with downstream stalled.
    drive_beat(OP_GET, 5'd3, 31'h100, 32'h0);
    enq_valid = 1'b1;
    tick();
    check("fill1_count", count, 1);
    check("fill1_deq_valid", deq_valid, 1);
    check("fill1_src", deq_source, 3);
    drive_beat(OP_PUT_FULL, 5'd4, 31'h200, 32'hDEADBEEF);
    tick();
    enq_valid = 1'b0;
    check("fill2_count", count, 2);
    check("fill2_enq_ready", enq_ready, 0);
    check("fill2_src", deq_source, 3);
    check("fill2_addr", deq_address, 31'h100);
    check("fill2_op", deq_opcode, OP_GET);
    tick();
    check("hold_src", deq_source, 3);
    check("hold_count", count, 2);
    check("hold_enq_ready", enq_ready, 0);

    // Drain in order.
    deq_ready = 1'b1;
    #1;
    check("drain0_src", deq_source, 3);
    tick();
    check("drain1_src", deq_source, 4);
    check("drain1_data", deq_data, 32'hDEADBEEF);
    check("drain1_op", deq_opcode, OP_PUT_FULL);
    check("drain1_count", count, 1);
    check("drain1_enq_ready", enq_ready, 1);
    tick();
    check("drained_deq_valid", deq_valid, 0);
    check("drained_count", count, 0);

    // Streaming 10 beats through with both sides always ready.
    pops = 0;
    enq_valid = 1'b1;
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_beat(OP_GET, 5'(i), 31'(i * 4), 32'(i));
      #1;
      if (enq_valid && enq_ready) exp_q.push_back(5'(i));
      if (deq_valid && deq_ready) begin
        if (exp_q.size() == 0) check("stream_unexpected_pop", 1, 0);
        else begin
          check("stream_src", deq_source, exp_q.pop_front());
          pops++;
        end
      end
      tick();
`ifdef TL_A_QUEUE_FLOW_EN
      check("stream_count", count, 0);
`else
      check("stream_count", count, 1);
`endif
    end
    enq_valid = 1'b0;
    for (int k = 0; k < 8 && exp_q.size() != 0; k++) begin
      #1;
      if (deq_valid) begin
        check("stream_tail_src", deq_source, exp_q.pop_front());
        pops++;
      end
      tick();
    end
    check("stream_pops", pops, 10);
    check("stream_end_count", count, 0);

    // Reset pulse between edges discards a queued beat.
    deq_ready = 1'b0;
    drive_beat(OP_GET, 5'd9, 31'h40, 32'h0);
    enq_valid = 1'b1;
    tick();
    enq_valid = 1'b0;
    check("mid_pre_deq_valid", deq_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_deq_valid", deq_valid, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_enq_ready", enq_ready, 0);
    #1 reset_n = 1'b1;
    tick();
    check("mid_after_deq_valid", deq_valid, 0);
    check("mid_after_count", count, 0);
    tick();
    check("mid_after2_deq_valid", deq_valid, 0);

`ifdef TL_A_QUEUE_FLOW_EN
    // Bypass: empty queue, beat passes through in the same cycle.
    deq_ready = 1'b1;
    drive_beat(OP_GET, 5'd7, 31'h80, 32'h0);
    enq_valid = 1'b1;
    #1;
    check("flow_deq_valid", deq_valid, 1);
    check("flow_src", deq_source, 7);
    check("flow_enq_ready", enq_ready, 1);
    tick();
    enq_valid = 1'b0;
    #1;
    check("flow_count", count, 0);
    check("flow_after_deq_valid", deq_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #50000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
